// File: rtl/tx_frame_scheduler.sv
// Transmit framing scheduler: arbitrates TLP/DLLP byte sources into one K/D-flagged framed stream.
// Optional macro TX_NULLIFY_EN adds tlp_nullify, which ends the flagged TLP with EDB instead of END.
module tx_frame_scheduler #(
    parameter int MAX_TLP_BYTES = 512,
    parameter int DLLP_BYTES    = 6,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tlp_valid,
    input  logic [7:0] tlp_data,
    input  logic       tlp_last,
`ifdef TX_NULLIFY_EN
    input  logic       tlp_nullify,
`endif
    output logic       tlp_ready,
    input  logic       dllp_valid,
    input  logic [7:0] dllp_data,
    output logic       dllp_ready,
    output logic [7:0] tx_data,
    output logic       tx_dk,
    output logic       tx_valid,
    output logic       underrun_err,
    output logic       oversize_err
);
    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] ENDT = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] PAD = 8'hF7;
    localparam int CMAX = (MAX_TLP_BYTES > DLLP_BYTES) ? MAX_TLP_BYTES : DLLP_BYTES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, TLP_BODY, DLLP_BODY, END_TOK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_dk_q, tx_dk_d;
    logic          tx_valid_q;
    logic          underrun_q, underrun_d;
    logic          oversize_q, oversize_d;
    logic          nullify_q, nullify_d;

    assign tlp_ready    = (state_q == TLP_BODY);
    assign dllp_ready   = (state_q == DLLP_BODY);
    assign tx_data      = tx_data_q;
    assign tx_dk        = tx_dk_q;
    assign tx_valid     = tx_valid_q;
    assign underrun_err = underrun_q;
    assign oversize_err = oversize_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        tx_data_d  = PAD;
        tx_dk_d    = 1'b1;
        underrun_d = 1'b0;
        oversize_d = 1'b0;
        nullify_d  = nullify_q;
        case (state_q)
            IDLE: begin
                // A TLP that has watched STARVE_LIMIT DLLP grants go by takes priority.
                if (dllp_valid && !(tlp_valid && streak_q == SW'(STARVE_LIMIT))) begin
                    tx_data_d = SDP;
                    cnt_d     = '0;
                    state_d   = DLLP_BODY;
                    if (streak_q != SW'(STARVE_LIMIT))
                        streak_d = streak_q + SW'(tlp_valid);
                end else if (tlp_valid) begin
                    tx_data_d = STP;
                    cnt_d     = '0;
                    streak_d  = '0;
                    state_d   = TLP_BODY;
                end
            end
            TLP_BODY: begin
                if (cnt_q == CW'(MAX_TLP_BYTES)) begin
                    tx_data_d  = EDB;
                    oversize_d = 1'b1;
                    state_d    = IDLE;
                end else if (!tlp_valid) begin
                    tx_data_d  = EDB;
                    underrun_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tx_data_d = tlp_data;
                    tx_dk_d   = 1'b0;
                    cnt_d     = cnt_q + CW'(1);
                    if (tlp_last) begin
                        state_d = END_TOK;
`ifdef TX_NULLIFY_EN
                        nullify_d = tlp_nullify;
`else
                        nullify_d = 1'b0;
`endif
                    end
                end
            end
            DLLP_BODY: begin
                if (!dllp_valid) begin
                    tx_data_d  = EDB;
                    underrun_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tx_data_d = dllp_data;
                    tx_dk_d   = 1'b0;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == CW'(DLLP_BYTES - 1))
                        state_d = END_TOK;
                end
            end
            default: begin
                // Closing token; IDLE arbitrates next cycle so the next start token follows directly.
                tx_data_d = nullify_q ? EDB : ENDT;
                nullify_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            tx_data_q  <= PAD;
            tx_dk_q    <= 1'b1;
            tx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            oversize_q <= 1'b0;
            nullify_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            tx_data_q  <= tx_data_d;
            tx_dk_q    <= tx_dk_d;
            tx_valid_q <= 1'b1;
            underrun_q <= underrun_d;
            oversize_q <= oversize_d;
            nullify_q  <= nullify_d;
        end
    end
endmodule
